layer_4_window_gen: RTL
=======================

// Module: layer_4_window_gen
// PURPOSE
//   Downstream of the layer-4 input tracker: captures the conv-4 output feature map
//   (10x10 pixels, 32 channels per pixel) as it streams out of conv_4.
//   Forms 3x3 sliding windows, valid padding, stride 1, giving an 8x8 = 64-window frame.
//   Emits one window per cycle to conv_5 as soon as each window is complete.
//   Holds a line buffer of 2*IMG_W+3 pixels, so conv_5 never waits for a full frame.
// PARAMETERS
//   IMG_W   10  feature-map width in pixels
//   IMG_H   10  feature-map height in pixels
//   CH      32  channels packed per pixel
//   DW      8   bits per channel
//   K       3   window edge (fixed 3; other values unsupported)
// PORTS
//   clk            in   1           rising-edge clock
//   rst            in   1           asynchronous reset, active-high
//   conv_start     in   1           1-cycle pulse: arm for a new frame
//   conv_4_ready   in   1           pixel strobe: conv_4_data valid this cycle
//   conv_4_data    in   CH*DW       one pixel, ch0 in LSBs
//   win_valid      out  1           window presented this cycle (1-cycle pulse)
//   win_data       out  9*CH*DW     window, p[r][c] at slice (r*3+c)*CH*DW; r0/c0 = oldest (top-left)
//   win_row        out  4           output row of window, 0..IMG_H-K
//   win_col        out  4           output col of window, 0..IMG_W-K
//   frame_done     out  1           1-cycle pulse with the last (64th) window
// BEHAVIOUR
//   Reset: state=IDLE; pix_row=0 and pix_col=0; win_valid=0, frame_done=0, win_row=0, win_col=0.
//     win_data and line-buffer contents are don't-care after reset and are not reset.
//   FSM:
//     IDLE -> BUSY on conv_start.
//     BUSY -> IDLE on the cycle the IMG_W*IMG_H-th pixel is accepted.
//   Accept rule: a pixel is accepted only when state==BUSY && conv_4_ready.
//     Strobes in IDLE are dropped. Any number of idle cycles may separate strobes.
//   Each accepted pixel:
//     - shifts into the line buffer;
//     - advances pix_col, wrapping at IMG_W-1 to 0 and incrementing pix_row.
//   Window emission:
//     - if the accepted pixel has pix_row>=K-1 && pix_col>=K-1, the next cycle drives
//       win_valid=1, win_data, win_row=pix_row-2 and win_col=pix_col-2.
//     - latency is exactly 1 cycle after the accepting edge; outputs are registered.
//     - otherwise win_valid=0 next cycle. win_data holds its last value when win_valid=0.
//   Pixels with pix_col<2 at row>=2 produce no window (no wrap-around windows).
//   frame_done rises together with the window at win_row=7, win_col=7.
//     After that pixel, counters return to 0 and the FSM is in IDLE.
//   No back-pressure: conv_5 must consume a window in the cycle it is valid.
//   conv_start while BUSY is ignored; the frame in progress continues.
//   conv_start and the final pixel in the same cycle: the final pixel completes the frame,
//     and the FSM goes to IDLE, not BUSY. conv_start must be re-issued.
//   Reset mid-frame: counters and outputs clear immediately (async). The next frame needs conv_start.
//   Counter widths: pix_row and pix_col are 4 bits; comparisons are unsigned.
// STRUCTURE
//   Shared package/header:
//     LAYER4_IMG_W = 10, LAYER4_IMG_H = 10, LAYER4_CH = 32, LAYER4_DW = 8, KERNEL = 3;
//     localparam PIX_W = CH*DW;
//     IDLE and BUSY state encodings.
//   Sub-module pixel_shift_line (DEPTH = 2*IMG_W+3, width PIX_W, shift-enable):
//     taps 0,1,2, IMG_W..IMG_W+2 and 2*IMG_W..2*IMG_W+2 form the window.
//   Top level holds the FSM, counters and output registers.
// TESTING
//   1 conv_start, then 100 back-to-back strobes with pixel i = {CH{i[7:0]}}:
//     exactly 64 win_valid pulses;
//     first window is 1 cycle after pixel 22, row0/col0, containing 0,1,2,10,11,12,20,21,22;
//     last window is row7/col7 (99 in the bottom-right slot) together with frame_done.
//   2 same frame with 0-3 random idle cycles between strobes ->
//     identical window sequence and contents to scenario 1.
//   3 40 strobes with no conv_start -> no win_valid.
//     Then conv_start plus a full frame -> result matches scenario 1.
//   4 rst pulse after pixel 55 -> win_valid=0 immediately.
//     conv_start plus a fresh frame -> first window again 0,1,2,10,...,22.
//   5 two frames back-to-back with conv_start one cycle after frame_done
//     (frame 2 values offset by 100) -> 128 windows; frame-2 first window is 100,101,102,...
//   6 conv_start asserted mid-frame -> ignored: still 64 windows, and frame_done once.

Source files
------------

// File: rtl/layer_4_window_gen_pkg.sv
// layer_4_window_gen_pkg: shared geometry, widths and FSM encoding for the layer-4 window generator
package layer_4_window_gen_pkg;
  localparam int LAYER4_IMG_W = 10;
  localparam int LAYER4_IMG_H = 10;
  localparam int LAYER4_CH = 32;
  localparam int LAYER4_DW = 8;
  localparam int KERNEL = 3;
  localparam int PIX_W = LAYER4_CH * LAYER4_DW;
  localparam int WIN_W = KERNEL * KERNEL * PIX_W;
  localparam int LINE_DEPTH = 2 * LAYER4_IMG_W + KERNEL;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
endpackage

// File: rtl/layer_4_window_gen_if.sv
// layer_4_window_gen_if: conv_4 pixel stream in, conv_5 window stream out
interface layer_4_window_gen_if;
  import layer_4_window_gen_pkg::*;
  logic             conv_start;
  logic             conv_4_ready;
  logic [PIX_W-1:0] conv_4_data;
  logic             win_valid;
  logic [WIN_W-1:0] win_data;
  logic [3:0]       win_row;
  logic [3:0]       win_col;
  logic             frame_done;
  modport master (output conv_start, conv_4_ready, conv_4_data,
                  input win_valid, win_data, win_row, win_col, frame_done);
  modport slave (input conv_start, conv_4_ready, conv_4_data,
                 output win_valid, win_data, win_row, win_col, frame_done);
endinterface

// File: rtl/layer_4_window_gen_pixel_shift_line.sv
// pixel_shift_line: pixel shift line whose newest slot is the incoming pixel, exposing the 3x3 window taps
module pixel_shift_line #(
  parameter int DEPTH = 23,
  parameter int W = 256,
  parameter int ROW = 10
) (
  input  logic           clk,
  input  logic           i_en,
  input  logic [W-1:0]   i_pix,
  output logic [9*W-1:0] o_win
);
  logic [W-1:0] r_sr [DEPTH-1];
  logic [W-1:0] w_line [DEPTH];
  assign w_line[0] = i_pix;
  for (genvar i = 1; i < DEPTH; i++) begin : g_line
    assign w_line[i] = r_sr[i-1];
  end
  // taps are read from the post-shift view so the window registered on the accepting edge includes the new pixel
  for (genvar r = 0; r < 3; r++) begin : g_r
    for (genvar c = 0; c < 3; c++) begin : g_c
      assign o_win[(r*3+c)*W +: W] = w_line[(2-r)*ROW + (2-c)];
    end
  end
  // shift one pixel deeper on every accepted pixel
  always_ff @(posedge clk)
    if (i_en) for (int k = 0; k < DEPTH-1; k++) r_sr[k] <= w_line[k];
endmodule

// File: rtl/layer_4_window_gen.sv
// layer_4_window_gen: forms 3x3 valid-padding windows from the conv-4 pixel stream for conv_5
module layer_4_window_gen
  import layer_4_window_gen_pkg::*;
(
  input logic clk,
  input logic rst,
  layer_4_window_gen_if.slave bus
);
  state_t           r_state, w_next;
  logic [3:0]       r_pix_row, r_pix_col;
  logic             r_win_valid, r_frame_done;
  logic [3:0]       r_win_row, r_win_col;
  logic [WIN_W-1:0] r_win_data, w_win;
  logic             w_accept, w_last_col, w_last, w_win_hit;
  assign w_accept   = (r_state == BUSY) && bus.conv_4_ready;
  assign w_last_col = r_pix_col == 4'(LAYER4_IMG_W - 1);
  assign w_last     = w_last_col && (r_pix_row == 4'(LAYER4_IMG_H - 1));
  assign w_win_hit  = w_accept && (r_pix_row >= 4'(KERNEL - 1)) && (r_pix_col >= 4'(KERNEL - 1));
  pixel_shift_line #(.DEPTH(LINE_DEPTH), .W(PIX_W), .ROW(LAYER4_IMG_W)) u_line (
    .clk  (clk),
    .i_en (w_accept),
    .i_pix(bus.conv_4_data),
    .o_win(w_win)
  );
  // arm on conv_start from IDLE; the final pixel always wins over a coincident conv_start
  always_comb
    w_next = (r_state == IDLE) ? (bus.conv_start ? BUSY : IDLE) : ((w_accept && w_last) ? IDLE : BUSY);
  // state and raster position of the next pixel to arrive
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= IDLE;
      r_pix_row <= '0;
      r_pix_col <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_pix_col <= w_last_col ? '0 : r_pix_col + 4'd1;
        r_pix_row <= w_last ? '0 : (w_last_col ? r_pix_row + 4'd1 : r_pix_row);
      end
    end
  // window strobe, position and end-of-frame marker, one cycle after the completing pixel
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_win_row    <= '0;
      r_win_col    <= '0;
    end else begin
      r_win_valid  <= w_win_hit;
      r_frame_done <= w_accept && w_last;
      if (w_win_hit) begin
        r_win_row <= r_pix_row - 4'(KERNEL - 1);
        r_win_col <= r_pix_col - 4'(KERNEL - 1);
      end
    end
  // window payload holds between windows and needs no reset
  always_ff @(posedge clk)
    if (w_win_hit) r_win_data <= w_win;
  assign bus.win_valid  = r_win_valid;
  assign bus.win_data   = r_win_data;
  assign bus.win_row    = r_win_row;
  assign bus.win_col    = r_win_col;
  assign bus.frame_done = r_frame_done;
endmodule
